// File: rtl/bnn_conv_pool_layer.sv
// Binary 3x3 convolution (XNOR-popcount + threshold) with optional 2x2 max-pool over one feature map.
// Latency: start sampled -> NF*IMG_DIM*IMG_DIM RUN cycles -> one FINISH cycle with done=1.
// Backpressure: none; inputs must be held stable while busy=1, start is ignored unless idle.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start             one-cycle request to process the feature map on pixels/weights/thresholds
//   pixels            IMG_DIM*IMG_DIM pixels of CIN binary channels, row-major
//   weights           NF filters of 3x3 kernel positions of CIN binary channels
//   thresholds        NF unsigned CW-bit popcount thresholds
//   busy, done        run in progress / one-cycle end-of-run pulse
//   fmap_out          NF*OD*OD binary outputs, filter-major then row-major
module bnn_conv_pool_layer #(
    parameter int IMG_DIM = 14,
    parameter int CIN     = 8,
    parameter int NF      = 4,
    parameter int POOL    = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [IMG_DIM*IMG_DIM*CIN-1:0]   pixels,
    input  logic [NF*9*CIN-1:0]              weights,
    input  logic [NF*$clog2(9*CIN+1)-1:0]    thresholds,
    output logic                             busy,
    output logic                             done,
    output logic [NF*((POOL != 0) ? IMG_DIM/2 : IMG_DIM)*((POOL != 0) ? IMG_DIM/2 : IMG_DIM)-1:0] fmap_out
);
    localparam int CW  = $clog2(9*CIN+1);
    localparam int OD  = (POOL != 0) ? IMG_DIM/2 : IMG_DIM;
    localparam int FW  = (NF > 1) ? $clog2(NF) : 1;
    localparam int DW  = $clog2(OD);
    localparam int PXW = $clog2(IMG_DIM*IMG_DIM*CIN);
    localparam int WTW = $clog2(NF*9*CIN);
    localparam int THW = $clog2(NF*CW);
    localparam int FMW = $clog2(NF*OD*OD);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [FW-1:0]       f_q, f_d;
    logic [DW-1:0]       r_q, r_d, c_q, c_d;
    logic [1:0]          q_q, q_d;
    logic                acc_q, acc_d;
    logic [NF*OD*OD-1:0] fmap_q, fmap_d;

    logic [CW-1:0]       cnt;
    logic                hot;

    // Popcount of XNOR over the 3x3xCIN window centred on the current input position.
    // Padded pixels read as 0 but still contribute their XNOR term.
    always_comb begin
        int  ir, ic, pr, pc, pidx, widx;
        logic inb, pbit, wbit;
        cnt = '0;
        ir  = (POOL != 0) ? 2*int'(r_q) + int'(q_q[1]) : int'(r_q);
        ic  = (POOL != 0) ? 2*int'(c_q) + int'(q_q[0]) : int'(c_q);
        for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
                pr   = ir + kr - 1;
                pc   = ic + kc - 1;
                inb  = (pr >= 0) && (pr < IMG_DIM) && (pc >= 0) && (pc < IMG_DIM);
                pidx = inb ? (pr*IMG_DIM + pc)*CIN : 0;
                widx = int'(f_q)*9*CIN + (kr*3 + kc)*CIN;
                for (int ch = 0; ch < CIN; ch++) begin
                    pbit = inb ? pixels[PXW'(pidx + ch)] : 1'b0;
                    wbit = weights[WTW'(widx + ch)];
                    cnt  = cnt + {{(CW-1){1'b0}}, ~(pbit ^ wbit)};
                end
            end
        end
        hot = (cnt >= thresholds[THW'(int'(f_q)*CW) +: CW]);
    end

    always_comb begin
        logic last_q;
        int   oidx;
        state_d = state_q;
        f_d     = f_q;
        r_d     = r_q;
        c_d     = c_q;
        q_d     = q_q;
        acc_d   = acc_q;
        fmap_d  = fmap_q;
        last_q  = (POOL == 0) || (q_q == 2'd3);
        oidx    = int'(f_q)*OD*OD + int'(r_q)*OD + int'(c_q);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    f_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    q_d     = '0;
                    acc_d   = 1'b0;
                    fmap_d  = '0;
                end
            end
            S_RUN: begin
                if (last_q) begin
                    fmap_d[FMW'(oidx)] = (POOL != 0) ? (acc_q | hot) : hot;
                    acc_d = 1'b0;
                    q_d   = '0;
                    if (c_q == DW'(OD-1)) begin
                        c_d = '0;
                        if (r_q == DW'(OD-1)) begin
                            r_d = '0;
                            if (f_q == FW'(NF-1)) begin
                                f_d     = '0;
                                state_d = S_FINISH;
                            end else begin
                                f_d = f_q + FW'(1);
                            end
                        end else begin
                            r_d = r_q + DW'(1);
                        end
                    end else begin
                        c_d = c_q + DW'(1);
                    end
                end else begin
                    acc_d = acc_q | hot;
                    q_d   = q_q + 2'd1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            q_q     <= '0;
            acc_q   <= 1'b0;
            fmap_q  <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            r_q     <= r_d;
            c_q     <= c_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            fmap_q  <= fmap_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_FINISH);
    assign fmap_out = fmap_q;

endmodule

// File: tb/tb_bnn_conv_pool_layer.sv
// Testbench for bnn_conv_pool_layer: default-parameter instance plus a small unpooled instance.
// Latency: runs of 785 cycles start->done on the default instance.
// Backpressure: none; stimulus is held while busy.
module tb_bnn_conv_pool_layer;
    localparam int D   = 14;
    localparam int C   = 8;
    localparam int N   = 4;
    localparam int CWT = 7;
    localparam int O   = 7;
    localparam int PW  = D*D*C;
    localparam int WW  = N*9*C;
    localparam int TWD = N*CWT;
    localparam int FM  = N*O*O;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [PW-1:0]  pixels;
    logic [WW-1:0]  weights;
    logic [TWD-1:0] thresholds;
    logic           busy, done;
    logic [FM-1:0]  fmap_out;

    logic           start2;
    logic [31:0]    pixels2;
    logic [17:0]    weights2;
    logic [4:0]     thresholds2;
    logic           busy2, done2;
    logic [15:0]    fmap2;

    int checks = 0;
    int errors = 0;
    logic [FM-1:0] exp_q[$];

    always #5 clk = ~clk;

    bnn_conv_pool_layer dut (
        .clk(clk), .rst(rst), .start(start), .pixels(pixels), .weights(weights),
        .thresholds(thresholds), .busy(busy), .done(done), .fmap_out(fmap_out)
    );

    bnn_conv_pool_layer #(.IMG_DIM(4), .CIN(2), .NF(1), .POOL(0)) dut_small (
        .clk(clk), .rst(rst), .start(start2), .pixels(pixels2), .weights(weights2),
        .thresholds(thresholds2), .busy(busy2), .done(done2), .fmap_out(fmap2)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Reference: full-resolution hot map first, then 2x2 max-pool.
    function automatic logic [FM-1:0] model(input logic [PW-1:0] px, input logic [WW-1:0] wt,
                                             input logic [TWD-1:0] th);
        logic hotm [N][D][D];
        logic [FM-1:0] res;
        int cnt, rr, cc;
        logic p;
        for (int f = 0; f < N; f++)
            for (int r = 0; r < D; r++)
                for (int c = 0; c < D; c++) begin
                    cnt = 0;
                    for (int kr = 0; kr < 3; kr++)
                        for (int kc = 0; kc < 3; kc++) begin
                            rr = r + kr - 1;
                            cc = c + kc - 1;
                            for (int ch = 0; ch < C; ch++) begin
                                if (rr >= 0 && rr < D && cc >= 0 && cc < D)
                                    p = px[(rr*D + cc)*C + ch];
                                else
                                    p = 1'b0;
                                if (p == wt[f*9*C + (kr*3 + kc)*C + ch]) cnt++;
                            end
                        end
                    hotm[f][r][c] = (cnt >= int'(th[f*CWT +: CWT]));
                end
        res = '0;
        for (int f = 0; f < N; f++)
            for (int r = 0; r < O; r++)
                for (int c = 0; c < O; c++)
                    res[f*O*O + r*O + c] = hotm[f][2*r][2*c] | hotm[f][2*r][2*c+1] |
                                           hotm[f][2*r+1][2*c] | hotm[f][2*r+1][2*c+1];
        return res;
    endfunction

    // Starts a run from a sample point 1 time unit after a rising edge; returns the sample
    // index at which done was seen (1 = the cycle right after start was sampled), -1 on timeout.
    task automatic run_map(input int pulse_at, output int done_cyc, output int busy_cyc);
        done_cyc = -1;
        busy_cyc = 0;
        if (done || busy) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 1000; n++) begin
            start = (n == pulse_at);
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = n;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start2 = 1'b1;
        pixels = '1; weights = '1; thresholds = {N{7'd41}};
        pixels2 = '1; weights2 = '1; thresholds2 = 5'd18;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl busy=%b done=%b required 0 0", busy, done);
        end
        checks++;
        if (fmap_out !== '0 || fmap2 !== '0) begin
            errors++; $display("FAIL reset_fmap fmap=%h fmap2=%h required 0", fmap_out, fmap2);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || busy2 !== 1'b0) begin
            errors++; $display("FAIL start_during_reset busy=%b busy2=%b required 0", busy, busy2);
        end
    endtask

    task automatic check_run(input string name, input int dc, input int bc);
        logic [FM-1:0] e;
        e = exp_q.pop_front();
        checks++;
        if (dc !== 785) begin
            errors++; $display("FAIL %s done_cycle got %0d required 785", name, dc);
        end
        checks++;
        if (bc !== 784) begin
            errors++; $display("FAIL %s busy_cycles got %0d required 784", name, bc);
        end
        checks++;
        if (fmap_out !== e) begin
            errors++; $display("FAIL %s fmap got %h required %h", name, fmap_out, e);
        end
    endtask

    task automatic test_all_ones();
        int dc, bc;
        pixels = '1; weights = '1; thresholds = {N{7'd41}};
        exp_q.push_back(model(pixels, weights, thresholds));
        run_map(0, dc, bc);
        check_run("all_ones", dc, bc);
        checks++;
        if (fmap_out !== {FM{1'b1}}) begin
            errors++; $display("FAIL all_ones_const fmap got %h required all ones", fmap_out);
        end
    endtask

    task automatic test_threshold_high();
        int dc, bc;
        pixels = '1; weights = '1; thresholds = {N{7'd73}};
        exp_q.push_back(model(pixels, weights, thresholds));
        run_map(0, dc, bc);
        check_run("thr_73", dc, bc);
        checks++;
        if (fmap_out !== '0) begin
            errors++; $display("FAIL thr_73_const fmap got %h required 0", fmap_out);
        end
    endtask

    task automatic test_zero_filter2();
        int dc, bc;
        logic [FM-1:0] e;
        pixels = '0; weights = '0; thresholds = '0;
        exp_q.push_back(model(pixels, weights, thresholds));
        run_map(0, dc, bc);
        check_run("zeros", dc, bc);
        checks++;
        if (fmap_out !== {FM{1'b1}}) begin
            errors++; $display("FAIL zeros_const fmap got %h required all ones", fmap_out);
        end
        thresholds[2*CWT +: CWT] = 7'd73;
        exp_q.push_back(model(pixels, weights, thresholds));
        run_map(0, dc, bc);
        check_run("filter2_off", dc, bc);
        e = '1;
        e[146:98] = '0;
        checks++;
        if (fmap_out !== e) begin
            errors++; $display("FAIL filter2_off_const fmap got %h required %h", fmap_out, e);
        end
    endtask

    task automatic test_random();
        int dc, bc;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < PW/32; i++) pixels[i*32 +: 32] = $urandom;
            for (int i = 0; i < WW/32; i++) weights[i*32 +: 32] = $urandom;
            for (int f = 0; f < N; f++) thresholds[f*CWT +: CWT] = 7'($urandom_range(30, 44));
            exp_q.push_back(model(pixels, weights, thresholds));
            run_map(0, dc, bc);
            check_run("random", dc, bc);
        end
    endtask

    task automatic test_mid_reset();
        int dc, bc, dones, busies;
        pixels = '1; weights = '1; thresholds = {N{7'd41}};
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n < 100; n++) begin
            @(posedge clk); #1;
        end
        // 99 RUN cycles evaluated: 24 pooled outputs written, 25th in progress.
        checks++;
        if (fmap_out[23:0] !== 24'hFFFFFF || fmap_out[FM-1:24] !== '0) begin
            errors++; $display("FAIL partial_fmap got %h required low 24 bits set only", fmap_out);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || fmap_out !== '0) begin
            errors++; $display("FAIL mid_reset busy=%b done=%b fmap=%h required 0 0 0", busy, done, fmap_out);
        end
        dones = 0; busies = 0;
        for (int n = 0; n < 800; n++) begin
            if (done) dones++;
            if (busy) busies++;
            @(posedge clk); #1;
        end
        checks++;
        if (dones != 0 || busies != 0) begin
            errors++; $display("FAIL after_reset done_pulses=%0d busy_cycles=%0d required 0 0", dones, busies);
        end
        exp_q.push_back(model(pixels, weights, thresholds));
        run_map(0, dc, bc);
        check_run("restart", dc, bc);
    endtask

    task automatic test_start_ignored();
        int dc, bc;
        logic [FM-1:0] held;
        for (int i = 0; i < PW/32; i++) pixels[i*32 +: 32] = $urandom;
        for (int i = 0; i < WW/32; i++) weights[i*32 +: 32] = $urandom;
        thresholds = {7'd38, 7'd36, 7'd40, 7'd37};
        exp_q.push_back(model(pixels, weights, thresholds));
        run_map(50, dc, bc);
        check_run("start_mid_run", dc, bc);
        held = fmap_out;
        // start sampled during FINISH must not launch a run
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || fmap_out !== held) begin
            errors++; $display("FAIL start_in_finish busy=%b fmap=%h required 0 %h", busy, fmap_out, held);
        end
    endtask

    task automatic test_nopool();
        int dc;
        dc = -1;
        pixels2 = '1; weights2 = '1; thresholds2 = 5'd18;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (done2) begin
                dc = n;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (dc !== 17) begin
            errors++; $display("FAIL nopool_done_cycle got %0d required 17", dc);
        end
        checks++;
        if (fmap2 !== 16'h0660) begin
            errors++; $display("FAIL nopool_fmap got %h required 0660", fmap2);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        pixels = '0; weights = '0; thresholds = '0;
        pixels2 = '0; weights2 = '0; thresholds2 = '0;
        test_reset();
        test_all_ones();
        test_threshold_high();
        test_zero_filter2();
        test_random();
        test_mid_reset();
        test_start_ignored();
        test_nopool();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
